// File: rtl/player_mover.sv
// player_mover: moves a SIZE x SIZE player square around the visible area on
// frame boundaries, freezes it once the game is won or lost, and produces a
// combinational "inside the square" pixel flag aligned with the scan position.
// Optional feature macro: PLAYER_BLINK_EN (blink the square while in LOST).
module player_mover #(
    parameter logic [9:0] START_X         = 10'd20,
    parameter logic [9:0] START_Y         = 10'd20,
    parameter logic [9:0] SIZE            = 10'd10,
    parameter logic [9:0] STEP            = 10'd2,
    parameter logic [7:0] FRAMES_PER_STEP = 8'd4,
    parameter logic [9:0] H_ACTIVE        = 10'd640,
    parameter logic [9:0] V_ACTIVE        = 10'd480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       win,
    input  logic       game_over,
    input  logic [9:0] xCount,
    input  logic [9:0] yCount,
    output logic       player,
    output logic [9:0] player_x,
    output logic [9:0] player_y
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WON  = 2'd1,
        LOST = 2'd2
    } state_t;

    localparam logic [7:0] LAST_COUNT = FRAMES_PER_STEP - 8'd1;
    localparam logic [9:0] MAX_X      = H_ACTIVE - SIZE;
    localparam logic [9:0] MAX_Y      = V_ACTIVE - SIZE;

    // Button order: [3]=up, [2]=down, [1]=left, [0]=right
    logic [3:0] btn_raw;
    logic [3:0] btn_sync;

    assign btn_raw = {up, down, left, right};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            // Two-flop synchronizer for one asynchronous button
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= btn_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign btn_sync[gi] = sync_reg;
        end
    endgenerate

    logic       frame_tick;
    logic       any_dir;
    state_t     state_reg, state_next;
    logic [7:0] count_reg, count_next;
    logic [9:0] x_reg, x_next;
    logic [9:0] y_reg, y_next;

    // First pixel of the first blanking line: the frame has just been drawn
    assign frame_tick = (xCount == 10'd0) && (yCount == V_ACTIVE);
    assign any_dir    = |btn_sync;

    // Saturating candidate positions for each direction (11-bit sums never wrap)
    logic [10:0] down_sum, right_sum;
    logic [9:0]  up_y, down_y, left_x, right_x;

    assign down_sum  = {1'b0, y_reg} + {1'b0, STEP};
    assign right_sum = {1'b0, x_reg} + {1'b0, STEP};
    assign up_y      = (y_reg < STEP) ? 10'd0 : (y_reg - STEP);
    assign left_x    = (x_reg < STEP) ? 10'd0 : (x_reg - STEP);
    assign down_y    = (down_sum  > {1'b0, MAX_Y}) ? MAX_Y : down_sum[9:0];
    assign right_x   = (right_sum > {1'b0, MAX_X}) ? MAX_X : right_sum[9:0];

    // Game state, step counter and position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= PLAY;
            count_reg <= LAST_COUNT;
            x_reg     <= START_X;
            y_reg     <= START_Y;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
        end
    end

    // End-of-game decision; win takes precedence when both flags are raised
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PLAY: begin
                if (win)
                    state_next = WON;
                else if (game_over)
                    state_next = LOST;
            end
            WON:     state_next = WON;
            LOST:    state_next = LOST;
            default: state_next = PLAY;
        endcase
    end

    // Per-frame movement: one axis per move, up > down > left > right
    always_comb begin
        count_next = count_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        if (frame_tick && (state_reg == PLAY)) begin
            if (!any_dir) begin
                // Idle: arm the counter so a fresh press moves on the next tick
                count_next = LAST_COUNT;
            end else if (count_reg == LAST_COUNT) begin
                count_next = 8'd0;
                if (btn_sync[3])
                    y_next = up_y;
                else if (btn_sync[2])
                    y_next = down_y;
                else if (btn_sync[1])
                    x_next = left_x;
                else
                    x_next = right_x;
            end else begin
                count_next = count_reg + 8'd1;
            end
        end
    end

    // Square hit test against the current scan position
    logic [10:0] x_end, y_end;
    logic        in_square;

    assign x_end     = {1'b0, x_reg} + {1'b0, SIZE};
    assign y_end     = {1'b0, y_reg} + {1'b0, SIZE};
    assign in_square = (xCount >= x_reg) && ({1'b0, xCount} < x_end) &&
                       (yCount >= y_reg) && ({1'b0, yCount} < y_end);

`ifdef PLAYER_BLINK_EN
    logic [4:0] blink_reg;

    // Frame counter that only advances after the game is lost
    always_ff @(posedge clk) begin
        if (rst)
            blink_reg <= 5'd0;
        else if (frame_tick && (state_reg == LOST))
            blink_reg <= blink_reg + 5'd1;
    end

    assign player = in_square && !((state_reg == LOST) && blink_reg[4]);
`else
    assign player = in_square;
`endif

    assign player_x = x_reg;
    assign player_y = y_reg;

endmodule

// File: tb/tb_player_mover.sv
// Scoreboard bench for player_mover: stimulus pushes expected outputs into a
// queue and raises a sample request; an independent monitor pops and compares.
module tb_player_mover;

    logic       clk = 1'b0;
    logic       rst, up, down, left, right, win, game_over;
    logic [9:0] x_count, y_count;
    logic       player;
    logic [9:0] player_x, player_y;

    always #5 clk = ~clk;

    player_mover dut (
        .clk       (clk),
        .rst       (rst),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .win       (win),
        .game_over (game_over),
        .xCount    (x_count),
        .yCount    (y_count),
        .player    (player),
        .player_x  (player_x),
        .player_y  (player_y)
    );

`ifdef PLAYER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    typedef struct {
        string      name;
        logic       ep;
        logic [9:0] ex;
        logic [9:0] ey;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic sample_req = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Monitor: compare DUT outputs against the oldest expectation
    always @(negedge clk) begin
        if (sample_req) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: sample requested with no expectation queued");
            end else begin
                mon_e = sb_q.pop_front();
                checks += 3;
                $display("check %s: player=%0b x=%0d y=%0d", mon_e.name, player, player_x, player_y);
                if (player !== mon_e.ep) begin
                    errors++;
                    $display("FAIL %s player: got %0b expected %0b", mon_e.name, player, mon_e.ep);
                end
                if (player_x !== mon_e.ex) begin
                    errors++;
                    $display("FAIL %s player_x: got %0d expected %0d", mon_e.name, player_x, mon_e.ex);
                end
                if (player_y !== mon_e.ey) begin
                    errors++;
                    $display("FAIL %s player_y: got %0d expected %0d", mon_e.name, player_y, mon_e.ey);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        x_count = 10'd0;
        y_count = 10'd480;
        cyc(1);
        x_count = 10'd5;
        y_count = 10'd5;
        cyc(1);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        up = u; down = d; left = l; right = r;
        cyc(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic check(input string nm, input int sx, input int sy,
                         input logic ep, input int ex, input int ey);
        exp_t e;
        e.name = nm;
        e.ep   = ep;
        e.ex   = 10'(ex);
        e.ey   = 10'(ey);
        x_count = 10'(sx);
        y_count = 10'(sy);
        sb_q.push_back(e);
        sample_req = 1'b1;
        cyc(1);
        sample_req = 1'b0;
    endtask

    int exp_right[9] = '{22, 22, 22, 22, 24, 24, 24, 24, 26};

    initial begin
        rst = 1'b1; up = 0; down = 0; left = 0; right = 0;
        win = 0; game_over = 0; x_count = 10'd5; y_count = 10'd5;
        cyc(3);
        rst = 1'b0;

        // Reset position and square bounds
        check("rst_in_tl",   20, 20, 1'b1, 20, 20);
        check("rst_in_br",   29, 29, 1'b1, 20, 20);
        check("rst_out_x",   30, 20, 1'b0, 20, 20);
        check("rst_out_y",   20, 30, 1'b0, 20, 20);
        check("rst_out_xm",  19, 25, 1'b0, 20, 20);
        check("rst_out_ym",  25, 19, 1'b0, 20, 20);

        // Hold right for 9 ticks
        set_btn(0, 0, 0, 1);
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("right_t%0d", k + 1), exp_right[k], 20, 1'b1, exp_right[k], 20);
        end

        // Reset while right is held: first tick sees an empty synchronizer
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        tick();
        check("rst_hold_t1", 20, 20, 1'b1, 20, 20);
        tick();
        check("rst_hold_t2", 22, 20, 1'b1, 22, 20);

        // Walk up to y=4, then up+left together saturates y at 0
        set_btn(0, 0, 0, 0);
        do_reset();
        set_btn(1, 0, 0, 0);
        ticks(28);
        check("up_y6", 20, 6, 1'b1, 20, 6);
        tick();
        check("up_y4", 20, 4, 1'b1, 20, 4);
        set_btn(0, 0, 0, 0);
        tick();
        set_btn(1, 0, 1, 0);
        tick();
        check("ul_t1", 20, 2, 1'b1, 20, 2);
        ticks(3);
        check("ul_t4", 20, 2, 1'b1, 20, 2);
        tick();
        check("ul_t5", 20, 0, 1'b1, 20, 0);
        ticks(4);
        check("ul_t9", 20, 0, 1'b1, 20, 0);

        // Lose the game, then hold down: frozen (blinks if enabled)
        set_btn(0, 0, 0, 0);
        do_reset();
        set_btn(0, 0, 0, 1);
        tick();
        check("pre_lost", 22, 20, 1'b1, 22, 20);
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        set_btn(0, 1, 0, 0);
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1 || n == 10 || n == 15 || n == 16 || n == 20)
                check($sformatf("lost_f%0d", n), 22, 20,
                      (BLINK && n >= 16) ? 1'b0 : 1'b1, 22, 20);
        end
        do_reset();
        check("lost_rst", 20, 20, 1'b1, 20, 20);

        // Win and game_over together: WON, solid, frozen
        set_btn(0, 0, 0, 0);
        do_reset();
        win = 1'b1;
        game_over = 1'b1;
        cyc(1);
        win = 1'b0;
        game_over = 1'b0;
        cyc(2);
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        set_btn(0, 0, 0, 1);
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 5 || n == 17 || n == 20)
                check($sformatf("won_f%0d", n), 20, 20, 1'b1, 20, 20);
        end

        // Saturate at the right and bottom edges
        set_btn(0, 0, 0, 0);
        do_reset();
        set_btn(0, 0, 0, 1);
        ticks(1216);
        check("sat_x628", 628, 20, 1'b1, 628, 20);
        tick();
        check("sat_x630", 639, 29, 1'b1, 630, 20);
        ticks(100);
        check("sat_x_hold", 639, 20, 1'b1, 630, 20);
        check("sat_x_left", 629, 20, 1'b0, 630, 20);
        set_btn(0, 0, 0, 0);
        tick();
        set_btn(0, 1, 0, 0);
        ticks(896);
        check("sat_y468", 630, 468, 1'b1, 630, 468);
        tick();
        check("sat_y470", 639, 479, 1'b1, 630, 470);
        ticks(100);
        check("sat_y_hold", 639, 479, 1'b1, 630, 470);
        check("sat_y_above", 635, 469, 1'b0, 630, 470);

        cyc(2);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/player_mover.md
PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 Parameters SHALL be: START_X 10'd20 spawn left column; START_Y 10'd20 spawn top row; SIZE 10'd10 square side in pixels; STEP 10'd2 pixels per move; FRAMES_PER_STEP 8'd4 frames between moves; H_ACTIVE 10'd640; V_ACTIVE 10'd480.
REQ-002 clk  input  1  pixel clock; sole clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 up, down, left, right  input  1 each  raw asynchronous direction buttons, active-high.
REQ-005 win  input  1  registered win flag from the collision checker.
REQ-006 game_over  input  1  registered loss flag from the collision checker.
REQ-007 xCount, yCount  input  10 each  current scan position from the VGA timing generator.
REQ-008 player  output  1  high while the scan position is inside the player square.
REQ-009 player_x, player_y  output  10 each  registered top-left corner of the player square.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer; the move logic uses only synchronized values (2-cycle input latency).
REQ-011 frame_tick SHALL be a 1-cycle internal pulse when xCount==0 and yCount==V_ACTIVE; position changes only on frame_tick, so player is stable across every active frame.
REQ-012 States SHALL be PLAY, WON, LOST; reset enters PLAY.
REQ-013 PLAY->WON when win==1; PLAY->LOST when game_over==1 and win==0 (win wins if both are high); WON and LOST are held until rst.
REQ-014 In WON/LOST, player_x/player_y SHALL not change.
REQ-015 Step counter (8 bits): on frame_tick in PLAY with any direction held, if counter==FRAMES_PER_STEP-1 the player moves and the counter clears; otherwise it increments.
REQ-016 On frame_tick with no direction held, the counter SHALL load FRAMES_PER_STEP-1, so a fresh press moves on the first following tick.
REQ-017 Multiple held directions: one axis per move; priority up > down > left > right.
REQ-018 Moves SHALL saturate: up/left stop at 0 (a position below STEP goes to 0); down stops at V_ACTIVE-SIZE; right stops at H_ACTIVE-SIZE; no wrap-around.
REQ-019 player SHALL be combinational: player_x <= xCount < player_x+SIZE and player_y <= yCount < player_y+SIZE, using 11-bit sums with no overflow; same-cycle alignment with the wall, border and end-zone pixel signals.
REQ-020 A move that would enter a wall SHALL NOT be blocked here; wall detection belongs to the collision checker.

Reset
REQ-021 With rst high at a clk edge: player_x=START_X, player_y=START_Y, state=PLAY, counter=FRAMES_PER_STEP-1, synchronizers=0.
REQ-022 Reset mid-frame or mid-hold SHALL take effect at that edge; held buttons move again no earlier than the second frame_tick after release of rst (synchronizer refill plus tick).
REQ-023 player SHALL reflect the reset position on the first cycle after reset.

Configuration
REQ-024 Macro PLAYER_BLINK_EN: when defined, in LOST a 5-bit frame counter runs on frame_tick and player is gated off while counter bit 4 is 1 (16 frames on, 16 off); in PLAY/WON player is solid. Undefined: no blink counter; player is solid in all states.

Verification
REQ-025 Reset, then scan (20,20) and (29,29) -> player=1; (30,20) and (20,30) -> player=0; player_x=20, player_y=20.
REQ-026 Hold right for 9 frame_ticks -> player_x steps 20->22 at tick 1, 24 at tick 5, 26 at tick 9; player_y stays 20.
REQ-027 Hold up and left together from (20,4), 4 ticks apart -> y 4->2->0->0, x stays 20.
REQ-028 Raise game_over in PLAY, then hold down -> position frozen for 10 frames; rst -> (20,20); with PLAYER_BLINK_EN, player=0 during frames 16-31 of LOST.
REQ-029 Assert win and game_over on the same cycle -> state WON; a later game_over pulse has no effect; movement frozen.
REQ-030 Position at (630,470), hold right then down -> x and y saturate at 630 and 470, never wrap to 0.
